result_byte_scanner: RTL and testbench
======================================

# result_byte_scanner

Upstream feeder for the two-digit seven-segment driver on the Zedboard FP32 adder demo. It latches each 32-bit adder result and presents one byte of it at a time on an 8-bit output, which drives the display's `in` bus. A debounced push-button steps through the four bytes, most-significant first. A flag output marks an unviewed new result.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16, number of consecutive clk cycles the synchronized button must differ from its debounced state before that state flips; legal range 2..65535.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: rst, asynchronous, active-high; clock clk.
- btn  input  1  raw, asynchronous push-button (high = pressed).
- result  input  32  FP32 result from the adder.
- result_valid  input  1  single-cycle strobe; `result` is valid in the same cycle.
- byte_out  output  8  selected byte of the held result; feeds the display driver's 8-bit input.
- byte_idx  output  2  index of the displayed byte (3 = bits 31:24 ... 0 = bits 7:0).
- new_flag  output  1  high from capture of a result until the first button step after it.

## Operation
- Hold register (32 b): loads `result` on any clk edge with result_valid=1.
- Index register (2 b): set to 3 on capture; otherwise decrements modulo 4 on each step pulse (3→2→1→0→3).
- byte_out = hold[8*byte_idx+7 : 8*byte_idx]. This is a combinational mux of registered state, with no extra register stage.
- Synchronizer: two flops, btn → s1 → s2.
- Debouncer states are STABLE_LOW and STABLE_HIGH, held in the `stable` bit, plus a 16-bit counter `cnt`:
  - if s2 == stable: cnt ← 0.
  - else if cnt == DEBOUNCE_CYCLES-1: stable ← s2, cnt ← 0.
  - else: cnt ← cnt+1.
- Edge detect: `stable_d` is stable delayed one cycle. The step pulse is stable & ~stable_d, so it fires on press only. Release never steps.
- new_flag: set on capture, cleared on a step pulse.
- Simultaneous capture and step in the same cycle: capture wins. Index becomes 3 and new_flag stays 1.
- Repeated result_valid: every strobe recaptures the hold register and resets the index to 3.
- Reset, asynchronous on every register:
  - hold = 0, byte_idx = 3, byte_out = 8'h00, new_flag = 0.
  - s1 = s2 = stable = stable_d = 0, cnt = 0.
- Reset asserted mid-debounce discards the count. A button held through reset release is treated as a fresh press: it steps once after the full debounce delay.

## Timing
- Capture latency: with result_valid=1 before edge N, hold, byte_idx=3, byte_out=result[31:24] and new_flag=1 are all valid after edge N.
- Button latency: btn rising before edge 1 (held steady) gives:
  - s2 = 1 after edge 2;
  - stable = 1 after edge 2+DEBOUNCE_CYCLES;
  - pulse high for exactly one cycle;
  - byte_idx/byte_out update at edge 3+DEBOUNCE_CYCLES (edge 19 for the default).
- Glitch rejection: any s2 excursion shorter than DEBOUNCE_CYCLES cycles produces no step and returns cnt to 0.
- Release uses the same filter, so a re-press needs DEBOUNCE_CYCLES stable low cycles in between.
- At most one step per debounced press, regardless of hold time.

## Test plan
- Reset behaviour: assert rst mid-operation with hold = 32'h40490FDB, byte_idx = 1. Required: immediately byte_out = 8'h00, byte_idx = 3, new_flag = 0, with no clk edge needed.
- Capture: pulse result_valid with result = 32'h40490FDB. Required: next cycle byte_out = 8'h40, byte_idx = 3, new_flag = 1.
- Byte stepping: four clean presses, each 40 cycles high and 40 cycles low, D = 16. Required:
  - byte_out sequence 8'h49, 8'h0F, 8'hDB, 8'h40;
  - new_flag = 0 after the first press;
  - each step lands exactly at edge 19 after btn rises.
- Glitch rejection: 15-cycle btn pulse, then bursts of 3-cycle chatter for 200 cycles. Required: no byte_idx change and cnt never reaches 15.
- Simultaneous events: time result_valid = 1 (result = 32'hC0000000) to coincide with the step pulse while byte_idx = 2. Required: byte_idx = 3, byte_out = 8'hC0, new_flag = 1.
- Long hold: btn held high for 1000 cycles. Required: exactly one step; a re-press after at least 16 low cycles steps again.

Source files
------------

// File: rtl/result_byte_scanner.sv
// Latches each FP32 adder result and shows one byte at a time, MSB first.
// A debounced push-button steps the displayed byte; new_flag marks an unviewed result.
module result_byte_scanner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn,
  input  logic [31:0] result,
  input  logic        result_valid,
  output logic [7:0]  byte_out,
  output logic [1:0]  byte_idx,
  output logic        new_flag
);

  typedef enum logic {
    STABLE_LOW  = 1'b0,
    STABLE_HIGH = 1'b1
  } deb_state_t;

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic        r_s1;
  logic        r_s2;
  deb_state_t  r_state;
  deb_state_t  w_next_state;
  logic [15:0] r_cnt;
  logic [15:0] w_next_cnt;
  logic        r_stable_d;
  logic        w_stable;
  logic        w_step;
  logic [31:0] r_hold;
  logic [1:0]  r_idx;
  logic        r_new;
  logic [7:0]  w_byte;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= btn;
      r_s2 <= r_s1;
    end
  end

  // Debouncer state, disagreement counter and delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= STABLE_LOW;
      r_cnt      <= 16'd0;
      r_stable_d <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_stable_d <= w_stable;
    end
  end

  // Debouncer next state: flip only after DEBOUNCE_CYCLES consecutive disagreements.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = 16'd0;
    case (r_state)
      STABLE_LOW: begin
        if (!r_s2) begin
          w_next_cnt = 16'd0;
        end else if (r_cnt == CNT_LAST) begin
          w_next_state = STABLE_HIGH;
          w_next_cnt   = 16'd0;
        end else begin
          w_next_cnt = r_cnt + 16'd1;
        end
      end
      STABLE_HIGH: begin
        if (r_s2) begin
          w_next_cnt = 16'd0;
        end else if (r_cnt == CNT_LAST) begin
          w_next_state = STABLE_LOW;
          w_next_cnt   = 16'd0;
        end else begin
          w_next_cnt = r_cnt + 16'd1;
        end
      end
      default: begin
        w_next_state = STABLE_LOW;
        w_next_cnt   = 16'd0;
      end
    endcase
  end

  assign w_stable = (r_state == STABLE_HIGH);
  // Press edge only; a release never steps.
  assign w_step   = w_stable & ~r_stable_d;

  // Capture wins over a coincident step so a fresh result is never skipped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= 32'h0000_0000;
      r_idx  <= 2'd3;
      r_new  <= 1'b0;
    end else if (result_valid) begin
      r_hold <= result;
      r_idx  <= 2'd3;
      r_new  <= 1'b1;
    end else if (w_step) begin
      r_idx  <= r_idx - 2'd1;
      r_new  <= 1'b0;
    end else begin
      r_hold <= r_hold;
      r_idx  <= r_idx;
      r_new  <= r_new;
    end
  end

  // Byte select straight from registered state, no extra pipeline stage.
  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      2'd3:    w_byte = r_hold[31:24];
      2'd2:    w_byte = r_hold[23:16];
      2'd1:    w_byte = r_hold[15:8];
      2'd0:    w_byte = r_hold[7:0];
      default: w_byte = 8'h00;
    endcase
  end

  assign byte_out = w_byte;
  assign byte_idx = r_idx;
  assign new_flag = r_new;

endmodule

// File: tb/tb_result_byte_scanner.sv
// Self-checking bench for result_byte_scanner: directed scenarios plus randomized
// button/result traffic compared against a sample-window reference model.
module tb_result_byte_scanner;

  localparam int D = 16;

  logic        clk;
  logic        rst;
  logic        btn;
  logic [31:0] result;
  logic        result_valid;
  logic [7:0]  byte_out;
  logic [1:0]  byte_idx;
  logic        new_flag;

  int checks;
  int errors;

  result_byte_scanner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn          (btn),
    .result       (result),
    .result_valid (result_valid),
    .byte_out     (byte_out),
    .byte_idx     (byte_idx),
    .new_flag     (new_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the debounced level flips once the last D synchronized
  // samples (button delayed two edges) all disagree with it.
  logic [31:0] m_hold;
  logic [1:0]  m_idx;
  bit          m_new;
  bit          m_stable;
  bit          m_pend;
  bit          m_hist[$];
  bit          m_seen[$];

  function automatic logic [7:0] m_byte();
    return m_hold[int'(m_idx)*8 +: 8];
  endfunction

  task automatic model_reset();
    m_hold = 32'h0; m_idx = 2'd3; m_new = 1'b0;
    m_stable = 1'b0; m_pend = 1'b0;
    m_hist.delete(); m_seen.delete();
  endtask

  task automatic model_edge();
    bit seen;
    bit flip;
    if (result_valid) begin
      m_hold = result; m_idx = 2'd3; m_new = 1'b1;
    end else if (m_pend) begin
      m_idx = m_idx - 2'd1; m_new = 1'b0;
    end
    m_hist.push_back(btn);
    seen = (m_hist.size() >= 3) ? m_hist[m_hist.size()-3] : 1'b0;
    if (m_hist.size() > 3) void'(m_hist.pop_front());
    m_seen.push_back(seen);
    if (m_seen.size() > D) void'(m_seen.pop_front());
    flip = (m_seen.size() == D);
    foreach (m_seen[i]) if (m_seen[i] == m_stable) flip = 1'b0;
    m_pend = flip && !m_stable;
    if (flip) begin
      m_stable = !m_stable;
      m_seen.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = 1'b0; result_valid = 1'b0; result = 32'h0;
    model_reset();
    tick(); tick();
    checks++;
    if (byte_out !== 8'h00 || byte_idx !== 2'd3 || new_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: byte_out=%h byte_idx=%0d new_flag=%b required 00/3/0", byte_out, byte_idx, new_flag);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_capture();
    result = 32'h40490FDB; result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    checks++;
    if (byte_out !== 8'h40 || byte_idx !== 2'd3 || new_flag !== 1'b1) begin
      errors++;
      $display("FAIL capture: byte_out=%h byte_idx=%0d new_flag=%b required 40/3/1", byte_out, byte_idx, new_flag);
    end
  endtask

  task automatic test_stepping();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h49; exp_b[1] = 8'h0F; exp_b[2] = 8'hDB; exp_b[3] = 8'h40;
    for (int p = 0; p < 4; p++) begin
      logic [1:0] prev;
      int at;
      prev = byte_idx; at = 0;
      btn = 1'b1;
      for (int i = 1; i <= 40; i++) begin
        tick();
        if (at == 0 && byte_idx !== prev) at = i;
      end
      checks++;
      if (at != 19) begin
        errors++;
        $display("FAIL step_latency: press %0d stepped at edge %0d required 19", p, at);
      end
      checks++;
      if (byte_out !== exp_b[p] || new_flag !== 1'b0) begin
        errors++;
        $display("FAIL step_byte: press %0d byte_out=%h new_flag=%b required %h/0", p, byte_out, new_flag, exp_b[p]);
      end
      btn = 1'b0;
      for (int i = 0; i < 40; i++) tick();
    end
  endtask

  task automatic test_glitch();
    logic [1:0] idx0;
    int max_cnt;
    int changes;
    idx0 = byte_idx; max_cnt = 0; changes = 0;
    btn = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (byte_idx !== idx0) changes++;
    end
    for (int i = 0; i < 200; i++) begin
      btn = ((i % 6) >= 3);
      tick();
      if (byte_idx !== idx0) changes++;
      if (i >= 4 && int'(dut.r_cnt) > max_cnt) max_cnt = int'(dut.r_cnt);
    end
    btn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (byte_idx !== idx0) changes++;
    end
    checks++;
    if (changes != 0) begin
      errors++;
      $display("FAIL glitch_no_step: byte_idx changed on %0d cycles required 0", changes);
    end
    checks++;
    if (max_cnt >= 15) begin
      errors++;
      $display("FAIL glitch_cnt: chatter cnt reached %0d required below 15", max_cnt);
    end
  endtask

  task automatic test_simultaneous();
    btn = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    btn = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    checks++;
    if (byte_idx !== 2'd2) begin
      errors++;
      $display("FAIL simul_setup: byte_idx=%0d required 2", byte_idx);
    end
    btn = 1'b1;
    for (int i = 0; i < 18; i++) tick();
    result = 32'hC0000000; result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    checks++;
    if (byte_idx !== 2'd3 || byte_out !== 8'hC0 || new_flag !== 1'b1) begin
      errors++;
      $display("FAIL simultaneous: byte_out=%h byte_idx=%0d new_flag=%b required C0/3/1", byte_out, byte_idx, new_flag);
    end
    for (int i = 0; i < 21; i++) tick();
    btn = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    checks++;
    if (byte_idx !== 2'd3 || new_flag !== 1'b1) begin
      errors++;
      $display("FAIL simul_after: byte_idx=%0d new_flag=%b required 3/1", byte_idx, new_flag);
    end
  endtask

  task automatic test_long_hold();
    int steps;
    int at;
    logic [1:0] prev;
    steps = 0;
    btn = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      prev = byte_idx;
      tick();
      if (byte_idx !== prev) steps++;
    end
    checks++;
    if (steps != 1) begin
      errors++;
      $display("FAIL long_hold: %0d steps required 1", steps);
    end
    btn = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    prev = byte_idx; at = 0;
    btn = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (at == 0 && byte_idx !== prev) at = i;
    end
    checks++;
    if (at != 19 || byte_idx !== m_idx) begin
      errors++;
      $display("FAIL repress: stepped at edge %0d byte_idx=%0d required edge 19 byte_idx=%0d", at, byte_idx, m_idx);
    end
    btn = 1'b0;
    for (int i = 0; i < 40; i++) tick();
  endtask

  task automatic test_reset_mid();
    int at;
    result = 32'h40490FDB; result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    for (int p = 0; p < 2; p++) begin
      btn = 1'b1;
      for (int i = 0; i < 40; i++) tick();
      btn = 1'b0;
      for (int i = 0; i < 40; i++) tick();
    end
    checks++;
    if (byte_idx !== 2'd1 || byte_out !== 8'h0F) begin
      errors++;
      $display("FAIL reset_setup: byte_idx=%0d byte_out=%h required 1/0F", byte_idx, byte_out);
    end
    btn = 1'b1;
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (byte_out !== 8'h00 || byte_idx !== 2'd3 || new_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: byte_out=%h byte_idx=%0d new_flag=%b required 00/3/0", byte_out, byte_idx, new_flag);
    end
    tick(); tick(); tick();
    rst = 1'b0;
    at = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (at == 0 && byte_idx !== 2'd3) at = i;
    end
    checks++;
    if (at != 19 || byte_idx !== 2'd2) begin
      errors++;
      $display("FAIL reset_held_btn: stepped at edge %0d byte_idx=%0d required edge 19 byte_idx=2", at, byte_idx);
    end
    btn = 1'b0;
    for (int i = 0; i < 40; i++) tick();
  endtask

  task automatic test_random();
    int run;
    run = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run == 0) begin
        btn = ~btn;
        run = $urandom_range(1, 40);
      end
      run--;
      result_valid = ($urandom_range(0, 59) == 0);
      result = $urandom;
      tick();
      result_valid = 1'b0;
      checks++;
      if (byte_out !== m_byte() || byte_idx !== m_idx || new_flag !== m_new) begin
        errors++;
        $display("FAIL random: cycle %0d byte_out=%h byte_idx=%0d new_flag=%b required %h/%0d/%b",
                 i, byte_out, byte_idx, new_flag, m_byte(), m_idx, m_new);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_capture();
    test_stepping();
    test_glitch();
    test_simultaneous();
    test_long_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
